// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled UART receiver with configurable frame format.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 vote at ticks 7/8/9.
module uart_receiver #(
  parameter int CLK_HZ = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] baud_sel,
  input  logic [4:0] line_control_reg,
  input  logic       serial_data_rx,
  output logic [7:0] data_output,
  output logic       active_flag,
  output logic       done_flag,
  output logic       parity_error,
  output logic       framing_error
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  localparam int DIV0 = (CLK_HZ + 8 * 2400) / (16 * 2400);
  localparam int DIV1 = (CLK_HZ + 8 * 4800) / (16 * 4800);
  localparam int DIV2 = (CLK_HZ + 8 * 9600) / (16 * 9600);
  localparam int DIV3 = (CLK_HZ + 8 * 19200) / (16 * 19200);
  state_t state, state_nx;
  logic [1:0] sync;
  logic line, line_d, fall, tick, samp, bit_val, fe_now, last_data, last_stop;
  logic [31:0] div, baud_cnt;
  logic [3:0] ph;
  logic [2:0] bit_idx;
  logic [4:0] lcr;
  logic [7:0] shreg;
  logic par, fe_acc, stop_idx;
  assign line = sync[1];
  assign fall = line_d & ~line;
  assign div = baud_sel == 2'd0 ? 32'(DIV0) : baud_sel == 2'd1 ? 32'(DIV1) :
               baud_sel == 2'd2 ? 32'(DIV2) : 32'(DIV3);
  // >= so a switch to a faster rate mid-count wraps immediately
  assign tick = baud_cnt >= div - 32'd1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] votes;
  assign samp = tick && ph == 4'd8;
  assign bit_val = (votes[0] & votes[1]) | (votes[0] & line) | (votes[1] & line);
  always_ff @(posedge clk)
    if (rst) votes <= 2'b11;
    else if (tick && ph == 4'd6) votes[0] <= line;
    else if (tick && ph == 4'd7) votes[1] <= line;
`else
  assign samp = tick && ph == 4'd7;
  assign bit_val = line;
`endif
  assign last_data = bit_idx == {1'b1, lcr[1:0]};
  assign last_stop = stop_idx == lcr[2];
  assign fe_now = fe_acc | ~bit_val;
  assign active_flag = state inside {START, DATA, PARITY, STOP};
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = fall ? START : IDLE;
      START:     if (samp) state_nx = bit_val ? IDLE : DATA;
      DATA:      if (samp && last_data) state_nx = lcr[3] ? PARITY : STOP;
      PARITY:    if (samp) state_nx = STOP;
      STOP:      if (samp && last_stop) state_nx = fe_now ? WAIT_HIGH : IDLE;
      WAIT_HIGH: if (line) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
      line_d <= 1'b1;
      baud_cnt <= '0;
      ph <= '0;
      bit_idx <= '0;
      lcr <= '0;
      shreg <= '0;
      par <= 1'b0;
      fe_acc <= 1'b0;
      stop_idx <= 1'b0;
      done_flag <= 1'b0;
      data_output <= '0;
      parity_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync <= {sync[0], serial_data_rx};
      line_d <= line;
      done_flag <= 1'b0;
      baud_cnt <= tick ? 32'd0 : baud_cnt + 32'd1;
      if (state == IDLE && fall) begin
        ph <= '0;
        lcr <= line_control_reg;
        bit_idx <= '0;
        shreg <= '0;
        par <= 1'b0;
        fe_acc <= 1'b0;
        stop_idx <= 1'b0;
      end else if (tick) ph <= ph + 4'd1;
      if (samp && state == DATA) begin
        shreg[bit_idx] <= bit_val;
        par <= par ^ bit_val;
        bit_idx <= bit_idx + 3'd1;
      end
      if (samp && state == PARITY) par <= par ^ bit_val;
      if (samp && state == STOP) begin
        fe_acc <= fe_now;
        stop_idx <= 1'b1;
        if (last_stop) begin
          done_flag <= 1'b1;
          data_output <= shreg;
          parity_error <= lcr[3] & (par ^ ~lcr[4]);
          framing_error <= fe_now;
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frame vectors plus glitch, framing-hold and mid-frame reset sequences.
module tb_uart_receiver;
  logic clk = 1'b0, rst, line;
  logic [1:0] baud_sel;
  logic [4:0] line_control_reg;
  logic [7:0] data_output;
  logic active_flag, done_flag, parity_error, framing_error;
  int n_pass = 0, n_total = 0, done_cnt = 0, d0;
  logic [7:0] prev;
  typedef struct {
    logic [1:0] bsel;
    logic [4:0] lcr;
    logic [4:0] lcr_mid;
    logic [7:0] data;
    logic       pbit;
    logic [1:0] stops;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;
  vec_t vecs[14];
  uart_receiver #(.CLK_HZ(1228800)) dut (
    .clk(clk), .rst(rst), .baud_sel(baud_sel), .line_control_reg(line_control_reg),
    .serial_data_rx(line), .data_output(data_output), .active_flag(active_flag),
    .done_flag(done_flag), .parity_error(parity_error), .framing_error(framing_error)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done_flag) done_cnt++;
  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else n_pass++;
  endfunction
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic tx(input logic [1:0] bsel, input logic [4:0] lcr, input logic [4:0] lcr_mid,
                    input logic [7:0] data, input logic pbit, input logic [1:0] stops, input bit rel);
    int bc, nb;
    bc = 512 >> bsel;
    nb = 5 + int'(lcr[1:0]);
    line_control_reg = lcr;
    line = 1'b0;
    clks(bc);
    line_control_reg = lcr_mid;
    for (int i = 0; i < nb; i++) begin
      line = data[i];
      if (i == 0) begin
        clks(bc / 2);
        chk("active_mid_frame", active_flag, 1);
        chk("hold_data", data_output, prev);
        clks(bc - bc / 2);
      end else clks(bc);
    end
    if (lcr[3]) begin
      line = pbit;
      clks(bc);
    end
    line = stops[0];
    clks(bc);
    if (lcr[2]) begin
      line = stops[1];
      clks(bc);
    end
    if (rel) begin
      line = 1'b1;
      clks(bc);
    end
  endtask
  initial begin
    vecs[0]  = '{2'd2, 5'b00011, 5'b00011, 8'hA5, 1'b0, 2'b11, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{2'd2, 5'b11011, 5'b11011, 8'h07, 1'b0, 2'b11, 8'h07, 1'b1, 1'b0};
    vecs[2]  = '{2'd2, 5'b00000, 5'b00000, 8'h1F, 1'b0, 2'b11, 8'h1F, 1'b0, 1'b0};
    vecs[3]  = '{2'd2, 5'b11011, 5'b11011, 8'h07, 1'b1, 2'b11, 8'h07, 1'b0, 1'b0};
    vecs[4]  = '{2'd2, 5'b01011, 5'b01011, 8'h07, 1'b0, 2'b11, 8'h07, 1'b0, 1'b0};
    vecs[5]  = '{2'd2, 5'b01011, 5'b01011, 8'h07, 1'b1, 2'b11, 8'h07, 1'b1, 1'b0};
    vecs[6]  = '{2'd2, 5'b00110, 5'b00110, 8'h55, 1'b0, 2'b11, 8'h55, 1'b0, 1'b0};
    vecs[7]  = '{2'd2, 5'b00001, 5'b00001, 8'h2A, 1'b0, 2'b11, 8'h2A, 1'b0, 1'b0};
    vecs[8]  = '{2'd2, 5'b00011, 5'b00011, 8'h3C, 1'b0, 2'b10, 8'h3C, 1'b0, 1'b1};
    vecs[9]  = '{2'd2, 5'b00111, 5'b00111, 8'h81, 1'b0, 2'b01, 8'h81, 1'b0, 1'b1};
    vecs[10] = '{2'd2, 5'b00011, 5'b00000, 8'hC3, 1'b0, 2'b11, 8'hC3, 1'b0, 1'b0};
    vecs[11] = '{2'd3, 5'b00011, 5'b00011, 8'h5A, 1'b0, 2'b11, 8'h5A, 1'b0, 1'b0};
    vecs[12] = '{2'd1, 5'b01110, 5'b01110, 8'h3F, 1'b1, 2'b11, 8'h3F, 1'b0, 1'b0};
    vecs[13] = '{2'd0, 5'b11000, 5'b11000, 8'h15, 1'b0, 2'b11, 8'h15, 1'b1, 1'b0};
    rst = 1'b1;
    line = 1'b1;
    baud_sel = 2'd2;
    line_control_reg = 5'b00011;
    clks(5);
    chk("rst_data", data_output, 0);
    chk("rst_active", active_flag, 0);
    chk("rst_done", done_flag, 0);
    chk("rst_pe", parity_error, 0);
    chk("rst_fe", framing_error, 0);
    rst = 1'b0;
    clks(20);
    prev = 8'h00;
    for (int v = 0; v < 14; v++) begin
      baud_sel = vecs[v].bsel;
      clks(40);
      d0 = done_cnt;
      tx(vecs[v].bsel, vecs[v].lcr, vecs[v].lcr_mid, vecs[v].data, vecs[v].pbit, vecs[v].stops, 1);
      clks(64);
      chk("vec_done_pulses", done_cnt - d0, 1);
      chk("vec_data", data_output, vecs[v].exp_data);
      chk("vec_parity_error", parity_error, vecs[v].exp_pe);
      chk("vec_framing_error", framing_error, vecs[v].exp_fe);
      chk("vec_idle_active", active_flag, 0);
      prev = vecs[v].exp_data;
    end
    baud_sel = 2'd2;
    clks(40);
    d0 = done_cnt;
    line = 1'b0;
    clks(20);
    chk("glitch_active_early", active_flag, 1);
    clks(12);
    line = 1'b1;
    clks(60);
    chk("glitch_active_late", active_flag, 0);
    chk("glitch_no_done", done_cnt - d0, 0);
    chk("glitch_data_kept", data_output, prev);
    d0 = done_cnt;
    tx(2'd2, 5'b00011, 5'b00011, 8'h81, 1'b0, 2'b00, 0);
    clks(3840);
    chk("fe_hold_active", active_flag, 0);
    chk("fe_hold_flag", framing_error, 1);
    chk("fe_hold_data", data_output, 8'h81);
    chk("fe_hold_single_done", done_cnt - d0, 1);
    line = 1'b1;
    clks(256);
    prev = 8'h81;
    d0 = done_cnt;
    tx(2'd2, 5'b00011, 5'b00011, 8'hA5, 1'b0, 2'b11, 1);
    clks(64);
    chk("rearm_done", done_cnt - d0, 1);
    chk("rearm_data", data_output, 8'hA5);
    chk("rearm_fe", framing_error, 0);
    d0 = done_cnt;
    line = 1'b0;
    clks(128);
    line = 1'b1;
    clks(128);
    line = 1'b0;
    clks(128);
    line = 1'b1;
    clks(128);
    clks(64);
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    chk("abort_active", active_flag, 0);
    chk("abort_data", data_output, 0);
    clks(2048);
    chk("abort_no_done", done_cnt - d0, 0);
    prev = 8'h00;
    d0 = done_cnt;
    tx(2'd2, 5'b00011, 5'b00011, 8'h3C, 1'b0, 2'b11, 1);
    clks(64);
    chk("after_abort_done", done_cnt - d0, 1);
    chk("after_abort_data", data_output, 8'h3C);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 baud_sel  input  2  baud rate: 00=2400, 01=4800, 10=9600, 11=19200.
REQ-005 line_control_reg  input  5  [1:0] word length (00=5, 01=6, 10=7, 11=8 bits); [2] stop bits (0=1, 1=2); [3] parity enable; [4] parity type (1=even, 0=odd).
REQ-006 serial_data_rx  input  1  asynchronous serial line; idles high.
REQ-007 data_output  output  8  received word, LSB-aligned; unused upper bits are 0.
REQ-008 active_flag  output  1  high while a frame is being received.
REQ-009 done_flag  output  1  one-clk pulse at frame completion.
REQ-010 parity_error  output  1  parity mismatch on the last frame.
REQ-011 framing_error  output  1  stop bit sampled low on the last frame.

Function
REQ-012 serial_data_rx passes through a 2-flop synchronizer (both flops reset to 1) before any use.
REQ-013 Oversample tick: 1-clk pulse every round(CLK_HZ/(16*baud)) clks, from a free-running counter that reloads on wrap using the current baud_sel (9600 at 50 MHz: 326).
REQ-014 FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 IDLE->START on a synchronized high-to-low transition; the tick phase counter clears to 0 and line_control_reg is latched for the frame.
REQ-016 START: at tick 8, line low -> DATA; line high -> IDLE (glitch rejection, no flags change).
REQ-017 DATA: sample every 16 ticks after mid-start, LSB first; after N bits (N from latched [1:0]) -> PARITY if parity enabled, else STOP.
REQ-018 PARITY: sample one bit; parity_error = 1 if XOR(data bits, parity bit) is not 0 for even, or not 1 for odd.
REQ-019 STOP: sample 1 or 2 stop bits per latched [2]; any stop sample low sets framing_error.
REQ-020 At the final stop sample: data_output, parity_error and framing_error update in the same clk that done_flag pulses; without parity, parity_error = 0.
REQ-021 After done: framing_error = 0 -> IDLE; framing_error = 1 -> WAIT_HIGH, which holds until the synchronized line is high, then -> IDLE.
REQ-022 active_flag is high in START, DATA, PARITY and STOP; low in IDLE and WAIT_HIGH.
REQ-023 data_output and both error flags hold their values until the next done_flag; a new start edge does not clear them.
REQ-024 Changes to line_control_reg mid-frame have no effect until the next start detection.

Reset
REQ-025 rst forces IDLE: data_output = 0, active_flag = 0, done_flag = 0, parity_error = 0, framing_error = 0, synchronizer flops = 1, counters = 0.
REQ-026 rst asserted mid-frame discards the partial frame with no done_flag pulse; reception re-arms on the next falling edge after rst deasserts.

Configuration
REQ-027 Macro UART_RX_MAJORITY_VOTE_EN defined: each bit value is the 2-of-3 majority of samples at ticks 7, 8 and 9 of the bit, and the start check uses the same vote.
REQ-028 Macro UART_RX_MAJORITY_VOTE_EN undefined: a single sample at tick 8 decides each bit; all other behaviour is identical.

Verification
REQ-029 9600 baud, LCR=5'b00011, send 0xA5 with 1 stop bit -> one done_flag pulse; data_output = 8'hA5; both errors = 0.
REQ-030 LCR=5'b11011 (8 bits, even parity), send 0x07 with parity bit 0 -> parity_error = 1, data_output = 8'h07.
REQ-031 LCR=5'b00000 (5 bits), send 0x1F -> data_output = 8'h1F; upper 3 bits = 0.
REQ-032 Stop bit driven low, then line held low for 3 frame times -> framing_error = 1, a single done_flag pulse, active_flag = 0 until the line returns high.
REQ-033 Low glitch of 4 oversample ticks on an idle line -> no done_flag; active_flag returns to 0 at tick 8.
REQ-034 rst asserted during data bit 3, then frame 0x3C sent -> no pulse for the aborted frame; data_output = 8'h3C after the second frame.
